// File: rtl/lcd_write_scheduler_pkg.sv
// Shared definitions for the LCD driver and its write scheduler.
// Cycle-count helpers keep both sides agreeing on driver timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        BOOT_RST  = 2'd0,
        BOOT_WAIT = 2'd1,
        IDLE      = 2'd2,
        HOLD      = 2'd3
    } lcd_state_e;

    localparam int INIT_CMDS = 4;

    // Cycles the driver spends on its init sequence after reset release
    function automatic int boot_cyc(input int clk_param, input int init_cmds = INIT_CMDS);
        return init_cmds * (clk_param + 1) + 2;
    endfunction

    // Cycles from one accepted character until the driver is back in WAIT
    function automatic int gap(input int clk_param);
        return clk_param + 3;
    endfunction

endpackage

// File: rtl/lcd_write_scheduler_if.sv
// Requester and driver-side signals of the LCD write scheduler.
// The master is the requester/driver side, the slave is the scheduler.
interface lcd_write_scheduler_if;
    logic [1:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] gnt;
    logic       lcd_reset;
    logic       lcd_wr_en;
    logic [7:0] lcd_data;
    logic       busy;
    logic [3:0] char_pos;

    modport master (
        output req, data0, data1,
        input  gnt, lcd_reset, lcd_wr_en, lcd_data, busy, char_pos
    );

    modport slave (
        input  req, data0, data1,
        output gnt, lcd_reset, lcd_wr_en, lcd_data, busy, char_pos
    );
endinterface

// File: rtl/lcd_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is issued.
// Grant is combinational and fully gated by en.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // 1 means requester 1 won the last grant, so requester 0 wins the first tie
    logic last;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end
endmodule

// File: rtl/lcd_write_scheduler.sv
// Boots the LCD driver, then arbitrates two character requesters and paces
// each write so the driver is idle in WAIT whenever the strobe arrives.
module lcd_write_scheduler #(
    parameter int CLK_PARAM        = 100000,
    parameter int CHARS_PER_SCREEN = 16,
    parameter int INIT_CMDS        = lcd_pkg::INIT_CMDS
) (
    input  logic                  clk,
    input  logic                  reset,
    lcd_write_scheduler_if.slave  bus
);
    import lcd_pkg::*;

    localparam int BOOT_CYC = boot_cyc(CLK_PARAM, INIT_CMDS);
    localparam int GAP      = gap(CLK_PARAM);
    localparam int LINE_GAP = GAP + BOOT_CYC;
    localparam int CW       = $clog2(LINE_GAP + 1);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] RST_LAST  = CW'(1);
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(LINE_GAP - 1);
    localparam logic [3:0]    LAST_POS  = 4'(CHARS_PER_SCREEN - 1);

    lcd_state_e    state;
    logic [CW-1:0] cnt;
    logic          line_end;
    logic [1:0]    gnt;
    logic          lcd_reset_q;
    logic          wr_en_q;
    logic [7:0]    data_q;
    logic [3:0]    pos_q;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (state == IDLE),
        .req   (bus.req),
        .gnt   (gnt)
    );

    assign bus.gnt       = gnt;
    assign bus.busy      = (state != IDLE);
    assign bus.lcd_reset = lcd_reset_q;
    assign bus.lcd_wr_en = wr_en_q;
    assign bus.lcd_data  = data_q;
    assign bus.char_pos  = pos_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= BOOT_RST;
            cnt         <= '0;
            line_end    <= 1'b0;
            lcd_reset_q <= 1'b1;
            wr_en_q     <= 1'b0;
            data_q      <= 8'h00;
            pos_q       <= 4'd0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                BOOT_RST: begin
                    if (cnt == RST_LAST) begin
                        cnt         <= '0;
                        lcd_reset_q <= 1'b0;
                        state       <= BOOT_WAIT;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                BOOT_WAIT: begin
                    if (cnt == BOOT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                IDLE: begin
                    if (|gnt) begin
                        data_q   <= gnt[1] ? bus.data1 : bus.data0;
                        wr_en_q  <= 1'b1;
                        // Last slot on screen: the driver re-inits after this write
                        line_end <= (pos_q == LAST_POS);
                        pos_q    <= (pos_q == LAST_POS) ? 4'd0 : pos_q + 4'd1;
                        cnt      <= '0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == (line_end ? LINE_LAST : GAP_LAST)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: state <= BOOT_RST;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Scoreboard bench for lcd_write_scheduler with CLK_PARAM=4
// (BOOT_CYC=22, GAP=7, LINE_GAP=29); cycle 0 is the cycle reset is released in.
module tb_lcd_write_scheduler;

    typedef struct {
        logic [1:0] gnt;
        logic [7:0] data;
        logic [3:0] pos;
        int         cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   errors;
    int   wr_cnt;
    int   wr_base;
    exp_t q[$];
    exp_t cur;
    logic pend_wr;
    logic pend_low;

    lcd_write_scheduler_if bus();

    lcd_write_scheduler #(.CLK_PARAM(4), .CHARS_PER_SCREEN(16), .INIT_CMDS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d, input logic [3:0] p, input int c);
        exp_t e;
        e.gnt = g; e.data = d; e.pos = p; e.cyc = c;
        q.push_back(e);
    endtask

    // Advance to just after the rising edge that starts cycle c
    task automatic goto(input int c);
        int n;
        n = 0;
        while (cyc < c) begin
            @(posedge clk); #1;
            n++;
            if (n > 5000) begin
                $display("FAIL goto_timeout: got cycle %0d, expected %0d", cyc, c);
                errors++;
                break;
            end
        end
    endtask

    task automatic check_reset_vals();
        check("rst_lcd_reset", bus.lcd_reset, 1);
        check("rst_wr_en",     bus.lcd_wr_en, 0);
        check("rst_lcd_data",  bus.lcd_data,  0);
        check("rst_gnt",       bus.gnt,       0);
        check("rst_busy",      bus.busy,      1);
        check("rst_char_pos",  bus.char_pos,  0);
    endtask

    task automatic check_boot_pulse();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("boot_lcd_reset", bus.lcd_reset, (i < 2) ? 1 : 0);
        end
    endtask

    // Monitor: every grant pops one expectation; the write strobe must follow for one cycle
    always @(negedge clk) begin
        if (!reset) begin
            pend_wr  = 1'b0;
            pend_low = 1'b0;
        end else begin
            if (bus.lcd_wr_en) wr_cnt++;
            if (pend_wr) begin
                check("wr_en_pulse", bus.lcd_wr_en, 1);
                check("lcd_data",    bus.lcd_data,  cur.data);
                check("char_pos",    bus.char_pos,  cur.pos);
                pend_wr  = 1'b0;
                pend_low = 1'b1;
            end else if (pend_low) begin
                check("wr_en_end", bus.lcd_wr_en, 0);
                pend_low = 1'b0;
            end else if (bus.lcd_wr_en) begin
                errors++;
                $display("FAIL spurious_wr_en: got 1, expected 0 (cycle %0d)", cyc);
            end
            if (bus.gnt != 2'b00) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_gnt: got %0b, expected 00 (cycle %0d)", bus.gnt, cyc);
                end else begin
                    cur = q.pop_front();
                    check("gnt_value", bus.gnt, cur.gnt);
                    check("gnt_cycle", cyc,     cur.cyc);
                    pend_wr = 1'b1;
                end
            end
        end
    end

    initial begin
        tests = 0; errors = 0; wr_cnt = 0; wr_base = 0;
        pend_wr = 1'b0; pend_low = 1'b0;
        reset = 1'b0;
        bus.req = 2'b01; bus.data0 = 8'h30; bus.data1 = 8'h00;

        // Boot + line wrap: 16 grants 8 apart from cycle 24, 17th is 30 after the 16th
        for (int k = 0; k < 17; k++)
            push(2'b01, 8'(8'h30 + k), 4'((k + 1) % 16), (k < 16) ? 24 + 8 * k : 174);

        repeat (3) @(posedge clk);
        #2;
        check_reset_vals();
        @(posedge clk); #1 reset = 1'b1;
        check_boot_pulse();

        for (int k = 0; k < 17; k++) begin
            goto(((k < 16) ? 24 + 8 * k : 174) + 1);
            bus.data0 = 8'(8'h31 + k);
        end
        bus.req = 2'b00;

        // Stall: request raised mid-HOLD waits for the first IDLE cycle (182)
        push(2'b10, 8'h55, 4'd2, 182);
        goto(178);
        bus.req = 2'b10; bus.data1 = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_gnt",      bus.gnt,      0);
            check("stall_lcd_data", bus.lcd_data, 8'h40);
            check("stall_busy",     bus.busy,     1);
        end

        // Tie: pointer now favours requester 0
        push(2'b01, 8'h41, 4'd3, 190);
        push(2'b10, 8'h42, 4'd4, 198);
        push(2'b01, 8'h41, 4'd5, 206);
        push(2'b10, 8'h42, 4'd6, 214);
        goto(183);
        bus.req = 2'b11; bus.data0 = 8'h41; bus.data1 = 8'h42;
        goto(215);
        bus.req = 2'b00;

        // Reset three cycles into HOLD takes effect asynchronously
        goto(217);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        repeat (3) @(posedge clk);
        @(posedge clk); #1 reset = 1'b1;
        wr_base = wr_cnt;
        check_boot_pulse();
        check("reboot_char_pos", bus.char_pos, 0);

        // Dropped request during BOOT_WAIT leaves no trace
        goto(10); bus.req = 2'b01;
        goto(11); bus.req = 2'b00;
        goto(23); @(negedge clk);
        check("boot_busy_end", bus.busy, 1);
        goto(24); @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_gnt",  bus.gnt,  0);
        goto(39); @(negedge clk);
        check("dropped_no_wr", wr_cnt - wr_base, 0);

        // Fresh pointer after reset: requester 0 wins the first tie
        push(2'b01, 8'h41, 4'd1, 40);
        push(2'b10, 8'h42, 4'd2, 48);
        goto(40); bus.req = 2'b11;
        goto(49); bus.req = 2'b00;
        goto(60);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
